// File: rtl/dec_exe_pipe_reg_pkg.sv
// Shared types and constants for the decode->execute pipeline register.
// Holds the decoded-instruction and bypass-flag structures plus the pipe FSM states.
package dec_exe_pipe_reg_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic            valid;
        logic [6:0]      opcode;
        logic [4:0]      dst_reg;
        logic            reg_write_enable;
        logic [4:0]      src_reg_1;
        logic [4:0]      src_reg_2;
        logic [XLEN-1:0] src_data_1;
        logic [XLEN-1:0] src_data_2;
        logic [XLEN-1:0] imm;
    } inst_decoded_t;

    typedef struct packed {
        logic dep_src1;
        logic dep_src2;
    } bypass_t;

    typedef enum logic {
        RUN      = 1'b0,
        LTU_WAIT = 1'b1
    } pipe_state_e;

    localparam inst_decoded_t INST_BUBBLE = '0;

endpackage

// File: rtl/dec_exe_pipe_reg_operand_fwd_mux.sv
// Per-source operand select: a pending load result beats everything, then the
// nearest producer (execute) beats the older one (memory), else the register file value.
module operand_fwd_mux
    import dec_exe_pipe_reg_pkg::*;
(
    input  logic            ltu_sel,
    input  logic            exe_sel,
    input  logic            mem_sel,
    input  logic [XLEN-1:0] exe_result,
    input  logic [XLEN-1:0] mem_result,
    input  logic [XLEN-1:0] reg_data,
    output logic [XLEN-1:0] data
);

    always_comb begin
        if (ltu_sel) begin
            data = mem_result;
        end else if (exe_sel) begin
            data = exe_result;
        end else if (mem_sel) begin
            data = mem_result;
        end else begin
            data = reg_data;
        end
    end

endmodule

// File: rtl/dec_exe_pipe_reg.sv
// Decode->execute pipeline register with operand forwarding, load-to-use bubble
// insertion, kill/stall handling and saturating stall/bubble counters.
module dec_exe_pipe_reg
    import dec_exe_pipe_reg_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  inst_decoded_t inst_dec_out,
    input  logic          load_to_use_hazard,
    input  bypass_t       ltu_bypass,
    input  bypass_t       exe_bypass,
    input  bypass_t       mem_bypass,
    input  logic [XLEN-1:0] exe_result,
    input  logic [XLEN-1:0] mem_result,
    input  logic          mem_stall,
    input  logic          kill_dec,
    input  logic          kill_exe,
    output inst_decoded_t inst_exe_in,
    output logic          hold_dec,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    pipe_state_e   state_q, state_d;
    logic [1:0]    ltu_q, ltu_d;
    inst_decoded_t inst_d;
    inst_decoded_t fwd_inst;
    logic [XLEN-1:0] src1_data, src2_data;
    logic          ltu_trigger;
    logic          bubble_inc;

    operand_fwd_mux u_fwd_src1 (
        .ltu_sel    (state_q == LTU_WAIT && ltu_q[0]),
        .exe_sel    (exe_bypass.dep_src1),
        .mem_sel    (mem_bypass.dep_src1),
        .exe_result (exe_result),
        .mem_result (mem_result),
        .reg_data   (inst_dec_out.src_data_1),
        .data       (src1_data)
    );

    operand_fwd_mux u_fwd_src2 (
        .ltu_sel    (state_q == LTU_WAIT && ltu_q[1]),
        .exe_sel    (exe_bypass.dep_src2),
        .mem_sel    (mem_bypass.dep_src2),
        .exe_result (exe_result),
        .mem_result (mem_result),
        .reg_data   (inst_dec_out.src_data_2),
        .data       (src2_data)
    );

    // The hazard is honoured only in RUN; in LTU_WAIT the load is already in memory.
    assign ltu_trigger = (state_q == RUN) && inst_dec_out.valid && load_to_use_hazard && !kill_dec;
    assign hold_dec    = rst && (mem_stall || ltu_trigger);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        fwd_inst            = inst_dec_out;
        fwd_inst.src_data_1 = src1_data;
        fwd_inst.src_data_2 = src2_data;

        state_d    = state_q;
        ltu_d      = ltu_q;
        inst_d     = inst_exe_in;
        bubble_inc = 1'b0;

        if (kill_exe) begin
            inst_d  = INST_BUBBLE;
            state_d = RUN;
            ltu_d   = 2'b00;
        end else if (!mem_stall) begin
            case (state_q)
                RUN: begin
                    if (ltu_trigger) begin
                        inst_d     = INST_BUBBLE;
                        state_d    = LTU_WAIT;
                        ltu_d      = {ltu_bypass.dep_src2, ltu_bypass.dep_src1};
                        bubble_inc = 1'b1;
                    end else begin
                        inst_d       = fwd_inst;
                        inst_d.valid = inst_dec_out.valid && !kill_dec;
                    end
                end
                LTU_WAIT: begin
                    inst_d  = kill_dec ? INST_BUBBLE : fwd_inst;
                    state_d = RUN;
                    ltu_d   = 2'b00;
                end
                default: begin
                    state_d = RUN;
                    ltu_d   = 2'b00;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            ltu_q       <= 2'b00;
            inst_exe_in <= INST_BUBBLE;
        end else begin
            state_q     <= state_d;
            ltu_q       <= ltu_d;
            inst_exe_in <= inst_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (hold_dec && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (bubble_inc && bubble_cnt != '1) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dec_exe_pipe_reg.sv
// Self-checking bench: directed scenarios then random traffic against a
// cycle-level behavioural model of the forwarding/bubble/kill/stall rules.
module tb_dec_exe_pipe_reg;
    import dec_exe_pipe_reg_pkg::*;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic            clk;
    logic            rst;
    inst_decoded_t   dec;
    logic            hazard;
    bypass_t         ltu_b, exe_b, mem_b;
    logic [XLEN-1:0] exe_result, mem_result;
    logic            mem_stall, kill_dec, kill_exe;
    inst_decoded_t   inst_exe_in;
    logic            hold_dec;
    logic [CNT_W-1:0] stall_cnt, bubble_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    inst_decoded_t m_inst;
    bit            m_ltu;
    bit [1:0]      m_q;
    int            m_stall, m_bubble;

    dec_exe_pipe_reg #(.CNT_W(CNT_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .inst_dec_out       (dec),
        .load_to_use_hazard (hazard),
        .ltu_bypass         (ltu_b),
        .exe_bypass         (exe_b),
        .mem_bypass         (mem_b),
        .exe_result         (exe_result),
        .mem_result         (mem_result),
        .mem_stall          (mem_stall),
        .kill_dec           (kill_dec),
        .kill_exe           (kill_exe),
        .inst_exe_in        (inst_exe_in),
        .hold_dec           (hold_dec),
        .stall_cnt          (stall_cnt),
        .bubble_cnt         (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] pick(bit from_load, bit e, bit m, logic [XLEN-1:0] own);
        if (from_load) return mem_result;
        if (e)         return exe_result;
        if (m)         return mem_result;
        return own;
    endfunction

    function automatic inst_decoded_t rand_inst();
        inst_decoded_t i;
        i.valid            = 1'b1;
        i.opcode           = 7'($urandom);
        i.dst_reg          = 5'($urandom);
        i.reg_write_enable = 1'($urandom);
        i.src_reg_1        = 5'($urandom);
        i.src_reg_2        = 5'($urandom);
        i.src_data_1       = $urandom;
        i.src_data_2       = $urandom;
        i.imm              = $urandom;
        return i;
    endfunction

    task automatic model_reset();
        m_inst   = '0;
        m_ltu    = 1'b0;
        m_q      = 2'b00;
        m_stall  = 0;
        m_bubble = 0;
    endtask

    task automatic drive_idle();
        dec        = '0;
        hazard     = 1'b0;
        ltu_b      = '0;
        exe_b      = '0;
        mem_b      = '0;
        exe_result = '0;
        mem_result = '0;
        mem_stall  = 1'b0;
        kill_dec   = 1'b0;
        kill_exe   = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".inst"},   128'(inst_exe_in), 128'(m_inst));
        check({tag, ".stall"},  128'(stall_cnt),   128'(m_stall));
        check({tag, ".bubble"}, 128'(bubble_cnt),  128'(m_bubble));
    endtask

    // One clock: predict from current inputs, check hold_dec, clock, check registers.
    task automatic step(input string tag);
        bit            trig, hold, n_ltu;
        bit [1:0]      n_q;
        inst_decoded_t f, n_inst;
        trig = !m_ltu && dec.valid && hazard && !kill_dec;
        hold = mem_stall || trig;
        f = dec;
        f.src_data_1 = pick(m_ltu && m_q[0], exe_b.dep_src1, mem_b.dep_src1, dec.src_data_1);
        f.src_data_2 = pick(m_ltu && m_q[1], exe_b.dep_src2, mem_b.dep_src2, dec.src_data_2);
        n_inst = m_inst;
        n_ltu  = m_ltu;
        n_q    = m_q;
        if (kill_exe) begin
            n_inst = '0; n_ltu = 1'b0; n_q = 2'b00;
        end else if (!mem_stall) begin
            if (!m_ltu && trig) begin
                n_inst = '0; n_ltu = 1'b1; n_q = {ltu_b.dep_src2, ltu_b.dep_src1};
                if (m_bubble < CNT_MAX) m_bubble++;
            end else if (!m_ltu) begin
                n_inst = f; n_inst.valid = dec.valid && !kill_dec;
            end else begin
                n_inst = kill_dec ? inst_decoded_t'('0) : f;
                n_ltu = 1'b0; n_q = 2'b00;
            end
        end
        if (hold && m_stall < CNT_MAX) m_stall++;
        #1;
        check({tag, ".hold"}, 128'(hold_dec), 128'(hold));
        @(posedge clk);
        #1;
        m_inst = n_inst;
        m_ltu  = n_ltu;
        m_q    = n_q;
        check_outputs(tag);
    endtask

    initial begin
        inst_decoded_t saved;
        int            saved_stall;

        rst = 1'b0;
        drive_idle();
        model_reset();
        #12;
        check("reset.hold", 128'(hold_dec), 128'(0));
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Exe result wins over mem result for the same source
        dec = rand_inst();
        exe_b.dep_src1 = 1'b1; exe_result = 32'h11;
        mem_b.dep_src1 = 1'b1; mem_result = 32'h22;
        step("exe_fwd");
        check("exe_fwd.src1", 128'(inst_exe_in.src_data_1), 128'(32'h11));

        // Mem forward on src2 only
        drive_idle();
        dec = rand_inst();
        mem_b.dep_src2 = 1'b1; mem_result = 32'h3333;
        step("mem_fwd");

        // kill_dec in RUN
        drive_idle();
        dec = rand_inst(); kill_dec = 1'b1;
        step("kill_dec");
        check("kill_dec.valid", 128'(inst_exe_in.valid), 128'(0));

        // Load-to-use: bubble then forwarded load data
        drive_idle();
        dec = rand_inst(); hazard = 1'b1; ltu_b = '{dep_src1: 1'b1, dep_src2: 1'b1};
        step("ltu0");
        check("ltu0.hold_was", 128'(inst_exe_in.valid), 128'(0));
        check("ltu0.bubble_cnt", 128'(bubble_cnt), 128'(1));
        mem_result = 32'hDEAD;
        step("ltu1");
        check("ltu1.src1", 128'(inst_exe_in.src_data_1), 128'(32'hDEAD));
        check("ltu1.src2", 128'(inst_exe_in.src_data_2), 128'(32'hDEAD));
        check("ltu1.valid", 128'(inst_exe_in.valid), 128'(1));
        // Back in RUN: the still-asserted hazard triggers a new bubble
        mem_result = 32'h5;
        step("ltu_rerun");

        // kill_exe while in LTU_WAIT -> RUN with ltu flags cleared
        drive_idle();
        dec = rand_inst(); hazard = 1'b1; mem_result = 32'hAB;
        kill_exe = 1'b1;
        step("kill_exe");
        check("kill_exe.valid", 128'(inst_exe_in.valid), 128'(0));
        drive_idle();
        dec = rand_inst(); mem_result = 32'hCAFE;
        step("after_kill_exe");
        check("after_kill_exe.src1", 128'(inst_exe_in.src_data_1), 128'(dec.src_data_1));

        // mem_stall for 3 cycles holds the register
        saved = m_inst; saved_stall = m_stall;
        drive_idle();
        dec = rand_inst(); mem_stall = 1'b1; hazard = 1'b1;
        for (int i = 0; i < 3; i++) step("mem_stall");
        check("mem_stall.inst", 128'(inst_exe_in), 128'(saved));
        check("mem_stall.cnt", 128'(stall_cnt), 128'(saved_stall + 3));

        // Async reset mid-run with a valid instruction in execute
        drive_idle();
        dec = rand_inst();
        step("pre_reset");
        rst = 1'b0;
        #1;
        model_reset();
        check("async_reset.valid", 128'(inst_exe_in.valid), 128'(0));
        check("async_reset.hold", 128'(hold_dec), 128'(0));
        check_outputs("async_reset");
        @(negedge clk);
        rst = 1'b1;

        // Saturation of stall_cnt
        drive_idle();
        mem_stall = 1'b1;
        for (int i = 0; i < CNT_MAX + 4; i++) step("sat");
        check("sat.stall_cnt", 128'(stall_cnt), 128'(CNT_MAX));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            dec        = rand_inst();
            dec.valid  = ($urandom_range(0, 7) != 0);
            hazard     = ($urandom_range(0, 3) == 0);
            ltu_b      = bypass_t'($urandom);
            exe_b      = bypass_t'($urandom);
            mem_b      = bypass_t'($urandom);
            exe_result = $urandom;
            mem_result = $urandom;
            mem_stall  = ($urandom_range(0, 7) == 0);
            kill_dec   = ($urandom_range(0, 15) == 0);
            kill_exe   = ($urandom_range(0, 15) == 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
